tile_select_decoder: RTL and testbench

//  Converts player selections into tile IDs: screen coordinate -> tile, the inverse of the tile->(x,y,colour) table.

---
 rtl/tile_pkg.sv | 35 +++
 rtl/tile_fifo.sv | 53 +++++
 rtl/tile_select_decoder.sv | 96 +++++++++
 tb/tb_tile_select_decoder.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/tile_pkg.sv
// rtl/tile_pkg.sv - shared tile grid constants, entry type and colour map
package tile_pkg;

    localparam int TILE_SIZE  = 8;
    localparam int GRID_TILES = 2;

    localparam logic [1:0] TILE_TL = 2'b00;
    localparam logic [1:0] TILE_TR = 2'b01;
    localparam logic [1:0] TILE_BL = 2'b10;
    localparam logic [1:0] TILE_BR = 2'b11;

    localparam logic [2:0] COL_TL = 3'b001;
    localparam logic [2:0] COL_TR = 3'b010;
    localparam logic [2:0] COL_BL = 3'b011;
    localparam logic [2:0] COL_BR = 3'b100;

    typedef logic [1:0] tile_id_t;

    typedef struct packed {
        logic [2:0] colour;
        tile_id_t   tile;
    } tile_entry_t;

    function automatic logic [2:0] tile_colour(input tile_id_t t);
        logic [2:0] c;
        case (t)
            TILE_TL: c = COL_TL;
            TILE_TR: c = COL_TR;
            TILE_BL: c = COL_BL;
            default: c = COL_BR;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/tile_fifo.sv
// rtl/tile_fifo.sv - synchronous FIFO holding decoded tile entries
module tile_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 5,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    // a push into a full FIFO is only legal when the head leaves on the same edge
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/tile_select_decoder.sv
// rtl/tile_select_decoder.sv - press detect, cursor capture, grid decode and tile queue
module tile_select_decoder
    import tile_pkg::*;
#(
    parameter int TILE_SIZE  = tile_pkg::TILE_SIZE,
    parameter int ORIGIN_X   = 0,
    parameter int ORIGIN_Y   = 0,
    parameter int FIFO_DEPTH = 4,
    localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic [7:0]    cursor_x,
    input  logic [7:0]    cursor_y,
    input  logic          select,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [1:0]    tile,
    output logic [2:0]    colour,
    output logic          miss,
    output logic          overflow,
    output logic [CW-1:0] count
);

    localparam int SPAN = GRID_TILES * TILE_SIZE;

    logic        sel_q, s1_valid_q, miss_q, ovf_q;
    logic        miss_d, ovf_d;
    logic [7:0]  s1_x_q, s1_y_q;
    logic        press, in_grid, push, pop, empty, full;
    logic [8:0]  dx, dy;
    tile_id_t    dec_tile;
    tile_entry_t dec_entry, head;

    assign press = select & ~sel_q;

    // 9-bit offsets: a cursor left of/above the origin wraps to >=256 and fails the span test
    assign dx       = {1'b0, s1_x_q} - 9'(ORIGIN_X);
    assign dy       = {1'b0, s1_y_q} - 9'(ORIGIN_Y);
    assign in_grid  = (dx < 9'(SPAN)) && (dy < 9'(SPAN));
    assign dec_tile = {dy >= 9'(TILE_SIZE), dx >= 9'(TILE_SIZE)};

    always_comb begin
        dec_entry        = '0;
        dec_entry.tile   = dec_tile;
        dec_entry.colour = tile_colour(dec_tile);
    end

    assign pop    = ~empty & out_ready;
    assign push   = s1_valid_q & in_grid & (~full | pop);
    assign ovf_d  = s1_valid_q & in_grid & full & ~pop;
    assign miss_d = s1_valid_q & ~in_grid;

    // sel_q resets high so a key held across reset release is not a press
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sel_q      <= 1'b1;
            s1_valid_q <= 1'b0;
            s1_x_q     <= '0;
            s1_y_q     <= '0;
            miss_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            sel_q      <= select;
            s1_valid_q <= press;
            if (press) begin
                s1_x_q <= cursor_x;
                s1_y_q <= cursor_y;
            end
            miss_q     <= miss_d;
            ovf_q      <= ovf_d;
        end
    end

    tile_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(tile_entry_t))
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push),
        .pop    (pop),
        .din    (dec_entry),
        .dout   (head),
        .empty  (empty),
        .full   (full),
        .count  (count)
    );

    assign out_valid = ~empty;
    assign tile      = empty ? 2'b00 : head.tile;
    assign colour    = empty ? 3'b000 : head.colour;
    assign miss      = miss_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_tile_select_decoder.sv
// tb/tb_tile_select_decoder.sv - randomized and directed bench for tile_select_decoder
module tb_tile_select_decoder;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       resetn, select, out_ready;
    logic [7:0] cursor_x, cursor_y;
    logic       va, vb, ma, mb, oa, ob;
    logic [1:0] ta, tb2;
    logic [2:0] ca, cb, na, nb;

    int total = 0;
    int bad   = 0;

    int mtile [2][DEPTH];
    int mcnt  [2];
    bit em [2];
    bit eo [2];
    bit pend, prev_sel;
    int px, py;

    tile_select_decoder #(.TILE_SIZE(8), .ORIGIN_X(0), .ORIGIN_Y(0), .FIFO_DEPTH(DEPTH)) dut_a (
        .clk(clk), .resetn(resetn), .cursor_x(cursor_x), .cursor_y(cursor_y), .select(select),
        .out_valid(va), .out_ready(out_ready), .tile(ta), .colour(ca),
        .miss(ma), .overflow(oa), .count(na)
    );

    tile_select_decoder #(.TILE_SIZE(8), .ORIGIN_X(20), .ORIGIN_Y(0), .FIFO_DEPTH(DEPTH)) dut_b (
        .clk(clk), .resetn(resetn), .cursor_x(cursor_x), .cursor_y(cursor_y), .select(select),
        .out_valid(vb), .out_ready(out_ready), .tile(tb2), .colour(cb),
        .miss(mb), .overflow(ob), .count(nb)
    );

    always #5 clk = ~clk;

    function automatic int ox(input int i);
        return (i == 0) ? 0 : 20;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mcnt[i] = 0;
            em[i]   = 1'b0;
            eo[i]   = 1'b0;
        end
        pend     = 1'b0;
        prev_sel = 1'b1;
    endtask

    task automatic check_inst(input int i, input logic v, input logic [2:0] n, input logic [1:0] t,
                              input logic [2:0] c, input logic m, input logic o);
        int et;
        et = (mcnt[i] > 0) ? mtile[i][0] : 0;
        chk($sformatf("valid%0d", i),  32'(v), (mcnt[i] > 0) ? 1 : 0);
        chk($sformatf("count%0d", i),  32'(n), mcnt[i]);
        chk($sformatf("tile%0d", i),   32'(t), et);
        chk($sformatf("colour%0d", i), 32'(c), (mcnt[i] > 0) ? et + 1 : 0);
        chk($sformatf("miss%0d", i),   32'(m), em[i] ? 1 : 0);
        chk($sformatf("ovf%0d", i),    32'(o), eo[i] ? 1 : 0);
    endtask

    task automatic check_all();
        check_inst(0, va, na, ta, ca, ma, oa);
        check_inst(1, vb, nb, tb2, cb, mb, ob);
    endtask

    // Reference: advance the model by one clock edge, then compare both instances.
    task automatic tick();
        if (!resetn) begin
            model_reset();
        end else begin
            for (int i = 0; i < 2; i++) begin
                em[i] = 1'b0;
                eo[i] = 1'b0;
                if (out_ready && mcnt[i] > 0) begin
                    for (int k = 0; k < DEPTH - 1; k++) mtile[i][k] = mtile[i][k + 1];
                    mcnt[i]--;
                end
                if (pend) begin
                    if (px >= ox(i) && px < ox(i) + 16 && py < 16) begin
                        if (mcnt[i] < DEPTH) begin
                            mtile[i][mcnt[i]] = (py / 8) * 2 + (px - ox(i)) / 8;
                            mcnt[i]++;
                        end else begin
                            eo[i] = 1'b1;
                        end
                    end else begin
                        em[i] = 1'b1;
                    end
                end
            end
            pend     = select && !prev_sel;
            px       = int'(cursor_x);
            py       = int'(cursor_y);
            prev_sel = select;
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic press(input int x, input int y, input bit rc, input bit rd);
        cursor_x  = 8'(x);
        cursor_y  = 8'(y);
        select    = 1'b1;
        out_ready = rc;
        tick();
        select    = 1'b0;
        out_ready = rd;
        tick();
        out_ready = 1'b0;
        tick();
    endtask

    task automatic drain();
        out_ready = 1'b1;
        repeat (DEPTH + 2) tick();
        out_ready = 1'b0;
    endtask

    initial begin
        resetn    = 1'b0;
        select    = 1'b1;
        out_ready = 1'b0;
        cursor_x  = 8'd0;
        cursor_y  = 8'd0;
        model_reset();
        tick();
        tick();

        // held key across reset release: no press
        resetn = 1'b1;
        repeat (10) tick();
        chk("held_valid", 32'(va), 0);
        select = 1'b0;
        tick();

        // one press per quadrant
        press(3, 2, 0, 0);
        chk("lat_tile00", 32'(ta), 0);
        press(12, 5, 0, 0);
        press(4, 15, 0, 0);
        press(15, 15, 0, 0);
        drain();

        // grid boundaries
        press(7, 7, 0, 0);
        press(8, 8, 0, 0);
        press(16, 0, 0, 0);
        press(0, 16, 0, 0);
        press(19, 0, 0, 0);
        press(20, 0, 0, 0);
        drain();

        // overflow with consumer stalled
        press(1, 1, 0, 0);
        press(9, 1, 0, 0);
        press(1, 9, 0, 0);
        press(9, 9, 0, 0);
        press(5, 12, 0, 0);
        chk("full_count", 32'(na), DEPTH);
        drain();

        // full FIFO with a pop on the decode edge: nothing dropped
        press(1, 1, 0, 0);
        press(9, 1, 0, 0);
        press(1, 9, 0, 0);
        press(9, 9, 0, 0);
        press(12, 2, 0, 1);
        chk("pushpop_count", 32'(na), DEPTH);
        drain();

        // asynchronous reset with entries queued and a press in flight
        press(2, 2, 0, 0);
        press(10, 10, 0, 0);
        cursor_x = 8'd3;
        cursor_y = 8'd3;
        select   = 1'b1;
        tick();
        #3;
        resetn = 1'b0;
        #1;
        model_reset();
        check_all();
        select = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        repeat (3) tick();

        // random presses and consumer behaviour
        for (int n = 0; n < 80; n++) begin
            press(int'($urandom_range(0, 45)), int'($urandom_range(0, 20)),
                  bit'($urandom % 2), bit'($urandom % 2));
            if ($urandom % 3 == 0) begin
                out_ready = bit'($urandom % 2);
                tick();
                out_ready = 1'b0;
            end
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
